// File: rtl/alu_exec_if.sv
// +----------------------------------------------------------------------------+
// | alu_exec_if : operation/result handshake bundle for alu_exec_unit          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface alu_exec_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_op;
    logic [2:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             ovf;
    logic             jr;

    // Register-read stage side: offers operations, consumes results.
    modport master (
        output in_valid, alu_op, funct, a, b, out_ready,
        input  in_ready, out_valid, result, hi, zero, ovf, jr
    );

    // Execute-unit side.
    modport slave (
        input  in_valid, alu_op, funct, a, b, out_ready,
        output in_ready, out_valid, result, hi, zero, ovf, jr
    );
endinterface

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// +----------------------------------------------------------------------------+
// | alu_exec_unit : registered ALU execute stage with iterative shift-add mult |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_exec_if.slave bus
);
    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_MUL_STEPS = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLT = 4'd5,
        OP_MUL = 4'd6,
        OP_SLL = 4'd7,
        OP_SRL = 4'd8,
        OP_JR  = 4'd9
    } op_t;

    state_t             r_state;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_count;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic               r_zero;
    logic               r_ovf;
    logic               r_jr;

    op_t                w_op;
    logic [5:0]         w_code;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic               w_out_free;
    logic               w_in_ready;
    logic               w_accept;

    assign w_code     = {bus.alu_op, bus.funct};
    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_in_ready = (r_state == S_IDLE) && w_out_free;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_op = OP_ADD;
        casez (w_code)
            6'b000???: w_op = OP_ADD;
            6'b001???: w_op = OP_SUB;
            6'b010000: w_op = OP_ADD;
            6'b010001: w_op = OP_SUB;
            6'b010010: w_op = OP_AND;
            6'b010011: w_op = OP_OR;
            6'b010100: w_op = OP_XOR;
            6'b010101,
            6'b010110,
            6'b010111: w_op = OP_SLT;
            6'b011110: w_op = OP_MUL;
            6'b110???: w_op = OP_SLL;
            6'b111???: w_op = (bus.funct == 3'b111) ? OP_JR : OP_SRL;
            default:   w_op = OP_ADD;
        endcase
    end

    assign w_sum  = bus.a + bus.b;
    assign w_diff = bus.a - bus.b;

    // Signed overflow: operands agree in sign (add) / differ (sub) and result sign flips.
    always_comb begin
        w_res = w_sum;
        w_ovf = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (bus.a[MSB] == bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (bus.a[MSB] != bus.b[MSB]) && (w_diff[MSB] != bus.a[MSB]);
            end
            OP_AND:  w_res = bus.a & bus.b;
            OP_OR:   w_res = bus.a | bus.b;
            OP_XOR:  w_res = bus.a ^ bus.b;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLL:  w_res = bus.a << bus.b[SH_W-1:0];
            OP_SRL:  w_res = bus.a >> bus.b[SH_W-1:0];
            OP_JR:   w_res = bus.a;
            default: w_res = w_sum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_hi        <= '0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
            r_jr        <= 1'b0;
        end else begin
            // A load later in this block overrides the drain-clear.
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_op == OP_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
                            r_mplier <= bus.b;
                            r_acc    <= '0;
                            r_count  <= C_MUL_STEPS;
                            r_state  <= S_MUL;
                        end else begin
                            r_result    <= w_res;
                            r_zero      <= (w_res == '0);
                            r_ovf       <= w_ovf;
                            r_jr        <= (w_op == OP_JR);
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - 1'b1;
                    if (r_count == CNT_W'(1)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (w_out_free) begin
                        r_result    <= r_acc[WIDTH-1:0];
                        r_hi        <= r_acc[2*WIDTH-1:WIDTH];
                        r_zero      <= (r_acc[WIDTH-1:0] == '0);
                        r_ovf       <= 1'b0;
                        r_jr        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.hi        = r_hi;
    assign bus.zero      = r_zero;
    assign bus.ovf       = r_ovf;
    assign bus.jr        = r_jr;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// +----------------------------------------------------------------------------+
// | tb_alu_exec_unit : scoreboard bench for alu_exec_unit (WIDTH=16)           |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_exec_unit;
    localparam int WIDTH = 16;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] hi;
        logic        zero;
        logic        ovf;
        logic        jr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [15:0] cur_hi = 16'h0;

    alu_exec_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference behaviour written from the opcode table with integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [2:0] fn,
                                   input logic [15:0] x, input logic [15:0] y,
                                   input logic [15:0] prev_hi);
        exp_t e;
        int sx, sy, s;
        logic [31:0] p;
        sx = int'($signed(x));
        sy = int'($signed(y));
        e.hi = prev_hi;
        e.jr = 1'b0;
        s = sx + sy;
        e.res = x + y;
        e.ovf = (s > 32767) || (s < -32768);
        if (op == 3'd1 || (op == 3'd2 && fn == 3'd1)) begin
            s = sx - sy;
            e.res = x - y;
            e.ovf = (s > 32767) || (s < -32768);
        end else if (op == 3'd2 && fn == 3'd2) begin
            e.res = x & y; e.ovf = 1'b0;
        end else if (op == 3'd2 && fn == 3'd3) begin
            e.res = x | y; e.ovf = 1'b0;
        end else if (op == 3'd2 && fn == 3'd4) begin
            e.res = x ^ y; e.ovf = 1'b0;
        end else if (op == 3'd2 && fn >= 3'd5) begin
            e.res = (sx < sy) ? 16'd1 : 16'd0; e.ovf = 1'b0;
        end else if (op == 3'd3 && fn == 3'd6) begin
            p = {16'h0, x} * {16'h0, y};
            e.res = p[15:0]; e.hi = p[31:16]; e.ovf = 1'b0;
        end else if (op == 3'd6) begin
            e.res = x << y[3:0]; e.ovf = 1'b0;
        end else if (op == 3'd7 && fn == 3'd7) begin
            e.res = x; e.jr = 1'b1; e.ovf = 1'b0;
        end else if (op == 3'd7) begin
            e.res = x >> y[3:0]; e.ovf = 1'b0;
        end
        e.zero = (e.res == 16'h0);
        return e;
    endfunction

    task automatic test_reset();
        logic [36:0] got;
        logic [36:0] want;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.alu_op = 3'd0; bus.funct = 3'd0;
        bus.a = 16'h0; bus.b = 16'h0; bus.out_ready = 1'b0;
        cur_hi = 16'h0;
        repeat (2) @(negedge clk);
        want = {1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1};
        got  = {bus.out_valid, bus.result, bus.hi, bus.zero, bus.ovf, bus.jr, bus.in_ready};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL reset_hold: {ov,res,hi,z,ovf,jr,rdy} got %h want %h", got, want);
        end
        rst_n = 1'b1;
        @(negedge clk);
        got = {bus.out_valid, bus.result, bus.hi, bus.zero, bus.ovf, bus.jr, bus.in_ready};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL reset_release: {ov,res,hi,z,ovf,jr,rdy} got %h want %h", got, want);
        end
    endtask

    task automatic test_alu_ops();
        logic [2:0]  t_op [12] = '{3'b010, 3'b010, 3'b010, 3'b110, 3'b111, 3'b111,
                                   3'b100, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000};
        logic [2:0]  t_fn [12] = '{3'b000, 3'b001, 3'b101, 3'b000, 3'b000, 3'b111,
                                   3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b101};
        logic [15:0] t_a  [12] = '{16'h7FFF, 16'h1234, 16'hFFFF, 16'h0003, 16'h8000, 16'h00AB,
                                   16'h0002, 16'hF0F0, 16'hF0F0, 16'hFF00, 16'h8000, 16'h0010};
        logic [15:0] t_b  [12] = '{16'h0001, 16'h1234, 16'h0001, 16'h0004, 16'h0003, 16'h0000,
                                   16'h0003, 16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0001, 16'hFFF0};
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.alu_op = t_op[i]; bus.funct = t_fn[i];
            bus.a = t_a[i]; bus.b = t_b[i];
            bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            e = model(t_op[i], t_fn[i], t_a[i], t_b[i], cur_hi);
            cur_hi = e.hi;
            sb.push_back(e);
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL alu_in_ready[%0d]: got %b want 1", i, bus.in_ready);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            n_cmp++;
            if (bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL alu_latency[%0d]: out_valid got %b want 1", i, bus.out_valid);
            end
            e = sb.pop_front();
            n_cmp++;
            if ({bus.result, bus.hi, bus.zero, bus.ovf, bus.jr} !== e) begin
                n_err++;
                $display("FAIL alu_result[%0d]: got res=%h hi=%h z=%b ovf=%b jr=%b want res=%h hi=%h z=%b ovf=%b jr=%b",
                         i, bus.result, bus.hi, bus.zero, bus.ovf, bus.jr,
                         e.res, e.hi, e.zero, e.ovf, e.jr);
            end
        end
    endtask

    task automatic test_mult();
        exp_t e;
        int   lat;
        logic busy_ok;
        @(negedge clk);
        bus.alu_op = 3'b011; bus.funct = 3'b110;
        bus.a = 16'hFFFF; bus.b = 16'hFFFF;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        e = model(3'b011, 3'b110, 16'hFFFF, 16'hFFFF, cur_hi);
        cur_hi = e.hi;
        sb.push_back(e);
        @(negedge clk);
        // An add stays on offer while the multiplier is busy; it must not be taken.
        bus.alu_op = 3'b010; bus.funct = 3'b000; bus.a = 16'h0005; bus.b = 16'h0005;
        lat = 0;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (lat != 17) begin
            n_err++;
            $display("FAIL mult_latency: got %0d edges want 17", lat);
        end
        n_cmp++;
        if (busy_ok !== 1'b1) begin
            n_err++;
            $display("FAIL mult_busy_in_ready: in_ready seen high while busy, want 0");
        end
        if (bus.out_valid === 1'b1) begin
            e = sb.pop_front();
            n_cmp++;
            if ({bus.result, bus.hi, bus.zero, bus.ovf, bus.jr} !== e) begin
                n_err++;
                $display("FAIL mult_result: got res=%h hi=%h z=%b ovf=%b jr=%b want res=%h hi=%h z=%b ovf=%b jr=%b",
                         bus.result, bus.hi, bus.zero, bus.ovf, bus.jr,
                         e.res, e.hi, e.zero, e.ovf, e.jr);
            end
        end else begin
            sb.delete();
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mult_no_sneak_add: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        @(negedge clk);
        bus.alu_op = 3'b010; bus.funct = 3'b000; bus.a = 16'd1; bus.b = 16'd2;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        e = model(3'b010, 3'b000, 16'd1, 16'd2, cur_hi);
        cur_hi = e.hi;
        sb.push_back(e);
        @(negedge clk);
        bus.a = 16'd10; bus.b = 16'd20;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if ({bus.out_valid, bus.result, bus.in_ready} !== {1'b1, 16'd3, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got ov=%b res=%h rdy=%b want ov=1 res=0003 rdy=0",
                         k, bus.out_valid, bus.result, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({bus.result, bus.hi, bus.zero, bus.ovf, bus.jr} !== e) begin
            n_err++;
            $display("FAIL bp_first_result: got res=%h want res=%h", bus.result, e.res);
        end
        e = model(3'b010, 3'b000, 16'd10, 16'd20, cur_hi);
        cur_hi = e.hi;
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_same_edge_load: out_valid got %b want 1", bus.out_valid);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({bus.result, bus.hi, bus.zero, bus.ovf, bus.jr} !== e) begin
            n_err++;
            $display("FAIL bp_second_result: got res=%h want res=%h", bus.result, e.res);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [15:0] x, y;
        int first, last, nout;
        first = -1; last = -1; nout = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
                nout++;
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL stream_extra: unexpected result %h", bus.result);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if ({bus.result, bus.hi, bus.zero, bus.ovf, bus.jr} !== e) begin
                        n_err++;
                        $display("FAIL stream_result[%0d]: got res=%h z=%b ovf=%b want res=%h z=%b ovf=%b",
                                 nout - 1, bus.result, bus.zero, bus.ovf, e.res, e.zero, e.ovf);
                    end
                end
            end
            if (cyc < 8) begin
                x = 16'($urandom);
                y = 16'($urandom);
                bus.alu_op = 3'b010; bus.funct = 3'b000; bus.a = x; bus.b = y;
                bus.in_valid = 1'b1;
                e = model(3'b010, 3'b000, x, y, cur_hi);
                cur_hi = e.hi;
                sb.push_back(e);
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        n_cmp++;
        if (nout != 8 || (last - first) != 7) begin
            n_err++;
            $display("FAIL stream_spacing: got %0d results over cycles %0d..%0d want 8 consecutive",
                     nout, first, last);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_mult();
        exp_t e;
        logic [36:0] got;
        logic [36:0] want;
        logic quiet;
        @(negedge clk);
        bus.alu_op = 3'b011; bus.funct = 3'b110; bus.a = 16'h1234; bus.b = 16'h5678;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        want = {1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1};
        got  = {bus.out_valid, bus.result, bus.hi, bus.zero, bus.ovf, bus.jr, bus.in_ready};
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL mid_mult_reset: {ov,res,hi,z,ovf,jr,rdy} got %h want %h", got, want);
        end
        cur_hi = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_err++;
            $display("FAIL mid_mult_aborted: aborted mult produced out_valid, want none");
        end
        bus.alu_op = 3'b010; bus.funct = 3'b000; bus.a = 16'd2; bus.b = 16'd3;
        bus.in_valid = 1'b1;
        e = model(3'b010, 3'b000, 16'd2, 16'd3, cur_hi);
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_latency: out_valid got %b want 1", bus.out_valid);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({bus.result, bus.hi, bus.zero, bus.ovf, bus.jr} !== e) begin
            n_err++;
            $display("FAIL post_reset_add: got res=%h hi=%h want res=%h hi=%h",
                     bus.result, bus.hi, e.res, e.hi);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mult();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mult();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
